// File: rtl/uart_pkg.sv
// Shared types and constants for the software-defined UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   DEFAULT_CLKS_PER_BIT = 434;
    localparam logic IDLE_LEVEL           = 1'b1;
    localparam logic START_LEVEL          = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter with synchronous restart: counts 0..CLKS_PER_BIT-1 and flags the last
// (bit_end) and second-to-last (pre_end) cycle of each bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic i_restart,
    output logic o_bit_end,
    output logic o_pre_end
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_restart || r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_bit_end = (r_count == LAST);
    assign o_pre_end = (r_count == PRE);

endmodule

// File: rtl/uart_tx_serialiser.sv
// UART transmit serialiser: start bit, LSB-first data, optional parity, stop bits.
// Parity is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_serialiser
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_start,
    output logic                  tx_ready,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  txd
);

    localparam int            BW        = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || CLKS_PER_BIT < 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
        $error("uart_tx_serialiser: illegal parameter value");
    end

    tx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_txd;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic w_restart;
    logic w_bit_end;
    logic w_pre_end;

    // The baud counter is parked at zero while idle so the start bit gets a full period.
    assign w_restart = clear || (r_state == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .i_restart(w_restart),
        .o_bit_end(w_bit_end),
        .o_pre_end(w_pre_end)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_txd     <= IDLE_LEVEL;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_start) begin
                        r_state   <= START;
                        r_shift   <= tx_data;
                        r_bit_cnt <= '0;
                        r_txd     <= START_LEVEL;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= (^tx_data) ^ PARITY_ODD[0];
`endif
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_txd   <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == LAST_DATA) begin
                            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state   <= PARITY;
                            r_txd     <= r_parity;
`else
                            r_state   <= STOP;
                            r_txd     <= IDLE_LEVEL;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_txd     <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_txd   <= IDLE_LEVEL;
                    end
                end
`endif
                STOP: begin
                    // tx_done is registered, so it is raised one cycle ahead of the final bit_end.
                    if (w_pre_end && r_bit_cnt == LAST_STOP) begin
                        r_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        if (r_bit_cnt == LAST_STOP) begin
                            r_state   <= IDLE;
                            r_bit_cnt <= '0;
                            r_ready   <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= IDLE_LEVEL;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign txd      = r_txd;
    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule

// File: doc/uart_tx_serialiser.md
Name: uart_tx_serialiser

Overview:
Transmit serialiser for the software-defined UART. It sits directly downstream of the N-bit data holding register and consumes that register's parallel output word. On a start handshake it captures the word and drives the serial line txd as one asynchronous frame, LSB first: start bit, data bits, optional parity bit, stop bits. Bit timing comes from an internal baud counter running on the system clock.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9)
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); must be >= 2
STOP_BITS, 1, number of stop bits (1 or 2)
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd

Ports:
clk  input  1  system clock; all logic on the rising edge
clear  input  1  synchronous, active-high reset
tx_data  input  DATA_WIDTH  parallel word from the holding register
tx_start  input  1  request to send tx_data
tx_ready  output  1  high only in IDLE; start is accepted only when this is high
tx_busy  output  1  high while a frame is in progress (the inverse of tx_ready)
tx_done  output  1  one-cycle pulse at the end of a frame
txd  output  1  serial line; idles high

Behaviour:
- Reset: when clear is high at a clk edge, the block enters IDLE and sets txd=1, tx_ready=1, tx_busy=0, tx_done=0. Shift register, bit counter and baud counter all go to 0. Reset has priority over every other input, including in mid-frame; the line returns high on the next edge.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Accept: when tx_start && tx_ready at an edge, tx_data is captured into the shift register at that edge and the state moves to START. From the following cycle, txd=0.
- While busy, tx_start and changes on tx_data are ignored.
- Bit timing: each bit is held on txd for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1. The bit_end tick fires at count CLKS_PER_BIT-1, advances the state or bit, and reloads the counter to 0.
- DATA: txd = shift[0]. At each bit_end the register shifts right. After DATA_WIDTH bits the state moves to PARITY (if compiled in) or to STOP.
- STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 during the final cycle of the last stop bit, and the next state is IDLE.
- Frame length: from the cycle after acceptance to the end of STOP, (1 + DATA_WIDTH + P + STOP_BITS)*CLKS_PER_BIT cycles, where P = 1 with parity and 0 without.
- Back-to-back: the block spends at least one IDLE cycle between frames, so the extra high cycle merely lengthens the stop bit. If tx_start is held high, the next start bit begins exactly 2 cycles after the tx_done cycle.
- Widths: the baud counter is $clog2(CLKS_PER_BIT) bits and the bit counter is $clog2(DATA_WIDTH+1) bits. Neither counter wraps except via an explicit reload.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted after DATA. txd = ^captured_data XOR PARITY_ODD for CLKS_PER_BIT cycles. The parity value is computed from the word captured at accept, not from the live tx_data.
- Undefined: no PARITY state and no parity logic; PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg holds:
  - the state typedef tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - the constant DEFAULT_CLKS_PER_BIT = 434;
  - the constants IDLE_LEVEL = 1'b1 and START_LEVEL = 1'b0.
- One sub-module: uart_baud_tick. It is a counter with a synchronous restart and parameter CLKS_PER_BIT, and outputs the bit_end pulse. The later receiver reuses it.

Test Plan:
1. Hold clear high for 3 cycles mid-idle -> txd=1, tx_ready=1, tx_busy=0, tx_done=0 on every cycle.
2. CLKS_PER_BIT=4, DATA_WIDTH=8, parity out; tx_data=0xA5 with a one-cycle tx_start -> txd carries 0, then 1,0,1,0,0,1,0,1, then 1, each level lasting 4 cycles (40 cycles total). tx_done pulses on cycle 40 and tx_ready rises on cycle 41.
3. During the 0xA5 frame at cycle 12, drive tx_start=1 with tx_data=0xFF -> ignored; the waveform is identical to scenario 2 and no second frame follows.
4. Hold tx_start high with 0x00 and then 0xFF -> two frames are sent. The second start bit begins 2 cycles after the first tx_done, and the data bits of the second frame are all 1.
5. Assert clear at cycle 15 of a frame -> on the next cycle txd=1, tx_ready=1 and tx_done stays 0. A subsequent 0x3C send produces a clean 40-cycle frame.
6. UART_TX_PARITY_EN defined, PARITY_ODD=0, tx_data=0x07 -> parity bit 1 and a 44-cycle frame. With PARITY_ODD=1 the parity bit is 0.
